pipe_add_sub: RTL

//   Parametrised, pipelined N-bit adder/subtractor with a valid/ready stream interface.
//   - The carry chain is split into STAGES equal segments, one register stage per segment.
//   - Lifts the combinational N-bit full-adder chain to high clock rates.
//   - Accepts one operation per cycle.
//   - Adds a subtract mode and a signed-overflow flag.
//   - Sits between operand producers and any datapath consumer that can apply backpressure.
//

---
 rtl/pipe_add_sub.sv | 76 +++++++
 1 files changed

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined N-bit adder/subtractor, one carry segment per stage, valid/ready stream
module pipe_add_sub #(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int SEG = N / STAGES;
  if (N < 1 || STAGES < 1 || STAGES > N || N % STAGES != 0) begin : g_bad_params
    $error("pipe_add_sub: need N >= 1, 1 <= STAGES <= N and N %% STAGES == 0");
  end
  logic         en;
  logic         v  [STAGES+1];
  logic         c  [STAGES+1];
  logic [N-1:0] pa [STAGES+1];
  logic [N-1:0] pb [STAGES+1];
  logic [N-1:0] ps [STAGES+1];
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign v[0]     = in_valid & en;
  assign c[0]     = sub ? 1'b1 : cin;
  assign pa[0]    = a;
  assign pb[0]    = sub ? ~b : b;
  assign ps[0]    = '0;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [SEG:0]   add;
    logic [N-1:0]   sn;
    logic           vq, cq;
    logic [N-1:0]   aq, bq, sq;
    assign add = {1'b0, pa[k][k*SEG +: SEG]} + {1'b0, pb[k][k*SEG +: SEG]} + (SEG+1)'(c[k]);
    // Splice this stage's segment into the partial sum carried from upstream
    always_comb begin
      sn = ps[k];
      sn[k*SEG +: SEG] = add[SEG-1:0];
    end
    // Stage register; data only loads with a real beat so idle outputs keep their last value
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vq <= 1'b0;
        cq <= 1'b0;
        aq <= '0;
        bq <= '0;
        sq <= '0;
      end else if (en) begin
        vq <= v[k];
        if (v[k]) begin
          cq <= add[SEG];
          aq <= pa[k];
          bq <= pb[k];
          sq <= sn;
        end
      end
    end
    assign v[k+1]  = vq;
    assign c[k+1]  = cq;
    assign pa[k+1] = aq;
    assign pb[k+1] = bq;
    assign ps[k+1] = sq;
  end
  assign out_valid = v[STAGES];
  assign sum       = ps[STAGES];
  assign cout      = c[STAGES];
  assign ovf       = (pa[STAGES][N-1] == pb[STAGES][N-1]) && (sum[N-1] != pa[STAGES][N-1]);
endmodule
